lsu_byte_seq: RTL and testbench
===============================

# lsu_byte_seq

Load/store sequencer between the MCU core's load-store path and the byte-wide data memory (8-bit data, 11-bit byte address, combinational read, write on clock edge when the store enable is high). It accepts one 32-bit byte, halfword or word request at a time over a valid/ready handshake. It splits the request into 1, 2 or 4 consecutive byte accesses, assembling load bytes little-endian or emitting store bytes little-endian. It then returns a single registered response with sign or zero extension applied.

## Interface
- `AW`, 11: data memory byte-address width; addresses wrap modulo 2^AW
- `DW`, 32: core data width; fixed at 32, other values unsupported
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  sequencer can accept; high only in IDLE
- `req_we_i`  in  1  1 = store, 0 = load
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `req_unsigned_i`  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
- `req_addr_i`  in  AW  byte address of least-significant byte
- `req_wdata_i`  in  DW  store data; low bytes used for byte/half
- `rsp_valid_o`  out  1  one-cycle response pulse
- `rsp_rdata_o`  out  DW  extended load data; 0 for stores; held until next response
- `rsp_err_o`  out  1  misalignment error, valid with `rsp_valid_o`
- `mem_addr_o`  out  AW  data memory byte address
- `mem_st_data_o`  out  8  data memory store byte
- `mem_st_en_o`  out  1  data memory write enable
- `mem_ld_data_i`  in  8  data memory combinational read byte

## Operation
- FSM states: IDLE, XFER, RESP.
- **IDLE**
  - `req_ready_o`=1; `mem_st_en_o`=0.
  - On `req_valid_i`&`req_ready_o`: latch addr, size, we, wdata and unsigned; set byte counter `cnt`=0; set nbytes = 1, 2 or 4; go to XFER.
- **XFER**
  - `mem_addr_o` = latched addr + `cnt` (mod 2^AW).
  - `mem_st_data_o` = wdata byte `cnt` (bits 8·cnt+7 : 8·cnt).
  - `mem_st_en_o` = latched we.
  - Loads: on each edge, capture `mem_ld_data_i` into byte `cnt` of the assembly register.
  - `cnt` increments each cycle. When `cnt`==nbytes−1, go to RESP after this edge.
- **RESP**
  - `rsp_valid_o`=1 for exactly one cycle; `mem_st_en_o`=0; then go to IDLE.
- Extension, loads only:
  - Byte: bits 31:8 = unsigned ? 0 : bit 7.
  - Half: bits 31:16 = unsigned ? 0 : bit 15.
  - Word: no extension.
  - Stores: `rsp_rdata_o`=0.
- `rsp_rdata_o` and `rsp_err_o` are registered and updated only on entry to RESP; they hold otherwise.
- Inputs are ignored outside the accepting edge. Request fields may change once accepted.

## Timing
- Cycle 0 is the accepting edge. Byte k is presented in cycle k+1. `rsp_valid_o` is high in cycle nbytes+1.
- Response latency: byte = 2 cycles, half = 3, word = 5.
- `req_ready_o` rises in the cycle after RESP. Max throughput is one word per 6 cycles.
- Address wrap: word at 0x7FE accesses 0x7FE, 0x7FF, 0x000, 0x001.
- Reset values: state IDLE, `cnt`=0, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `mem_addr_o`=0, `mem_st_data_o`=0, `mem_st_en_o`=0.
- Reset mid-XFER: abort immediately. Bytes already written stay written. No response is produced.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests are half with addr[0]=1, or word with addr[1:0]≠0.
  - Such a request skips XFER and goes IDLE→RESP. No memory cycle occurs (`mem_st_en_o` stays 0).
  - Response: `rsp_err_o`=1, `rsp_rdata_o`=0, latency 1 cycle.
- Undefined: `rsp_err_o` is tied 0. Misaligned accesses are performed bytewise with address wrap.

## Structure
- Package `lsu_pkg`: size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, nbytes lookup function.
- Sub-module `lsu_load_ext`: combinational size/unsigned extender from assembled 32-bit data to `rsp_rdata_o` next-value.

## Test plan
- Word store 0xDEADBEEF at 0x010 → writes EF, BE, AD, DE to 0x010–0x013 in cycles 1–4; `rsp_valid_o` in cycle 5; `rsp_rdata_o`=0.
- Byte load from address holding 0x80: signed → 0xFFFFFF80; unsigned → 0x00000080; response in cycle 2.
- Half load at 0x7FF with 0x7FF=0x34 and 0x000=0x92, signed, macro off → reads 0x7FF then 0x000; response 0xFFFF9234 in cycle 3, `rsp_err_o`=0.
- Same request with `LSU_MISALIGN_TRAP_EN` → `mem_st_en_o` never high; response in cycle 1 with `rsp_err_o`=1, data 0.
- Word store 0x11223344 at 0x020, `rst_ni` low during cycle 3 → only 0x020=0x44 and 0x021=0x33 change; no `rsp_valid_o`; `req_ready_o`=1 after release.
- `req_valid_i` held high with two byte loads → second accepted on the edge after the first RESP cycle; no request lost or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-wide load/store sequencer: size codes, FSM states
// and the request-size to byte-count lookup.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        RESP = 2'b10
    } state_t;

    // Size code 2'b11 is handled as a word access.
    function automatic logic [2:0] nbytes_of(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extender: widens assembled load data to 32 bits according to the
// access size and the unsigned flag.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ext
);

    logic fill_b;
    logic fill_h;

    assign fill_b = ~uns & data[7];
    assign fill_h = ~uns & data[15];

    always_comb begin
        ext = data;
        case (size)
            SZ_BYTE: ext = {{24{fill_b}}, data[7:0]};
            SZ_HALF: ext = {{16{fill_h}}, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer splitting 32-bit requests into byte-wide memory cycles.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests return an error response without touching memory.
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_st_data_o,
    output logic          mem_st_en_o,
    input  logic [7:0]    mem_ld_data_i
);

    state_t        state;
    logic [1:0]    cnt_q;
    logic [2:0]    nbytes_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    size_q;
    logic          we_q;
    logic          uns_q;
    logic [31:0]   asm_q;

    logic          ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [7:0]    mem_st_data_q;
    logic          mem_st_en_q;

    logic [31:0]   asm_next;
    logic [31:0]   ext_data;
    logic [1:0]    cnt_nxt;
    logic          last_byte;

    assign cnt_nxt   = cnt_q + 2'd1;
    assign last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));

    // The byte being read this cycle is merged in so the final edge can
    // register the extended result without an extra cycle.
    always_comb begin
        asm_next = asm_q;
        asm_next[{cnt_q, 3'b000} +: 8] = mem_ld_data_i;
    end

    lsu_load_ext u_ext (
        .data (asm_next),
        .size (size_q),
        .uns  (uns_q),
        .ext  (ext_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    logic rsp_err_q;

    assign misalign = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                      (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt_q         <= 2'd0;
            nbytes_q      <= 3'd1;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= SZ_BYTE;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            asm_q         <= '0;
            ready_q       <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_addr_q    <= '0;
            mem_st_data_q <= '0;
            mem_st_en_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid_i && ready_q) begin
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
                        size_q   <= req_size_i;
                        we_q     <= req_we_i;
                        uns_q    <= req_unsigned_i;
                        nbytes_q <= nbytes_of(req_size_i);
                        cnt_q    <= 2'd0;
                        asm_q    <= '0;
                        ready_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state         <= XFER;
                            mem_addr_q    <= req_addr_i;
                            mem_st_data_q <= req_wdata_i[7:0];
                            mem_st_en_q   <= req_we_i;
                        end
`else
                        state         <= XFER;
                        mem_addr_q    <= req_addr_i;
                        mem_st_data_q <= req_wdata_i[7:0];
                        mem_st_en_q   <= req_we_i;
`endif
                    end
                end
                XFER: begin
                    if (!we_q) begin
                        asm_q <= asm_next;
                    end
                    if (last_byte) begin
                        state       <= RESP;
                        cnt_q       <= 2'd0;
                        mem_st_en_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? '0 : ext_data;
`ifdef LSU_MISALIGN_TRAP_EN
                        rsp_err_q   <= 1'b0;
`endif
                    end else begin
                        cnt_q         <= cnt_nxt;
                        mem_addr_q    <= addr_q + AW'(cnt_nxt);
                        mem_st_data_q <= wdata_q[{cnt_nxt, 3'b000} +: 8];
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    ready_q     <= 1'b1;
                    mem_st_en_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_st_data_o = mem_st_data_q;
    assign mem_st_en_o   = mem_st_en_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed bench for lsu_byte_seq with a byte-wide memory model and a response scoreboard.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_byte_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [10:0] mem_addr;
    logic [7:0]  mem_st_data;
    logic        mem_st_en;
    logic [7:0]  mem_ld_data;

    logic [7:0]  mem [2048];
    logic        pre_we;
    logic [10:0] pre_addr;
    logic [7:0]  pre_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    lsu_byte_seq dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .mem_addr_o     (mem_addr),
        .mem_st_data_o  (mem_st_data),
        .mem_st_en_o    (mem_st_en),
        .mem_ld_data_i  (mem_ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; the bench preloads through the same write port as the DUT.
    assign mem_ld_data = mem[mem_addr];
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_st_en)
            mem[mem_addr] <= mem_st_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Issues one request, then waits (bounded) for its response and checks it
    // against the scoreboard entry pushed here.
    task automatic run_req(input string name, input logic we, input logic [1:0] size,
                           input logic uns, input logic [10:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input int exp_wr);
        exp_t e;
        int   lat;
        int   wr;
        logic seen;
        sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
        @(negedge clk);
        check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_addr     = ~addr;
        req_wdata    = ~wdata;
        lat  = 0;
        wr   = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (mem_st_en) wr++;
            if (rsp_valid) begin
                seen = 1'b1;
                check({name, "_sb"}, {31'b0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check({name, "_rdata"}, rsp_rdata, e.rdata);
                    check({name, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
                    check({name, "_lat"}, lat, e.lat);
                end
            end
        end
        check({name, "_seen"}, {31'b0, seen}, 32'd1);
        check({name, "_wr"}, wr, exp_wr);
        @(negedge clk);
        check({name, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
        check({name, "_ready_after"}, {31'b0, req_ready}, 32'd1);
        check({name, "_hold"}, rsp_rdata, exp_rdata);
    endtask

    initial begin
        exp_t e;
        int   accepts;
        int   got;
        int   t;
        int   acc_edge2;
        logic acc;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        pre_we       = 1'b0;
        pre_addr     = '0;
        pre_data     = '0;

        #12;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'b0, rsp_err}, 32'd0);
        check("rst_mem_addr", {21'b0, mem_addr}, 32'd0);
        check("rst_st_data", {24'b0, mem_st_data}, 32'd0);
        check("rst_st_en", {31'b0, mem_st_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        poke(11'h040, 8'h80);
        poke(11'h7FF, 8'h34);
        poke(11'h000, 8'h92);
        poke(11'h031, 8'h77);
        poke(11'h050, 8'hC3);
        for (int i = 0; i < 4; i++) poke(11'h020 + 11'(i), 8'hA5);

        run_req("st_word", 1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF, 32'h0, 1'b0, 5, 4);
        check("st_word_m0", {24'b0, mem[11'h010]}, 32'hEF);
        check("st_word_m1", {24'b0, mem[11'h011]}, 32'hBE);
        check("st_word_m2", {24'b0, mem[11'h012]}, 32'hAD);
        check("st_word_m3", {24'b0, mem[11'h013]}, 32'hDE);

        run_req("ld_byte_s", 1'b0, 2'b00, 1'b0, 11'h040, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
        run_req("ld_byte_u", 1'b0, 2'b00, 1'b1, 11'h040, 32'h0, 32'h00000080, 1'b0, 2, 0);
        run_req("ld_word", 1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 32'hDEADBEEF, 1'b0, 5, 0);
        run_req("ld_size3", 1'b0, 2'b11, 1'b1, 11'h010, 32'h0, 32'hDEADBEEF, 1'b0, 5, 0);
        run_req("ld_half_u", 1'b0, 2'b01, 1'b1, 11'h012, 32'h0, 32'h0000DEAD, 1'b0, 3, 0);
        run_req("ld_half_s", 1'b0, 2'b01, 1'b0, 11'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 3, 0);

        run_req("st_byte", 1'b1, 2'b00, 1'b0, 11'h030, 32'hFFFFFF5A, 32'h0, 1'b0, 2, 1);
        check("st_byte_m0", {24'b0, mem[11'h030]}, 32'h5A);
        check("st_byte_m1", {24'b0, mem[11'h031]}, 32'h77);

`ifdef LSU_MISALIGN_TRAP_EN
        run_req("ld_half_wrap", 1'b0, 2'b01, 1'b0, 11'h7FF, 32'h0, 32'h0, 1'b1, 1, 0);
        run_req("st_word_mis", 1'b1, 2'b10, 1'b0, 11'h031, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
        check("st_word_mis_m", {24'b0, mem[11'h031]}, 32'h77);
`else
        run_req("ld_half_wrap", 1'b0, 2'b01, 1'b0, 11'h7FF, 32'h0, 32'hFFFF9234, 1'b0, 3, 0);
`endif

        // Reset lands in cycle 3 of a word store: only the first two bytes reach memory.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 11'h020;
        req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_st_en", {31'b0, mem_st_en}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_rel_no_rsp", {31'b0, rsp_valid}, 32'd0);
            check("rst_rel_ready", {31'b0, req_ready}, 32'd1);
        end
        check("rst_mid_m0", {24'b0, mem[11'h020]}, 32'h44);
        check("rst_mid_m1", {24'b0, mem[11'h021]}, 32'h33);
        check("rst_mid_m2", {24'b0, mem[11'h022]}, 32'hA5);
        check("rst_mid_m3", {24'b0, mem[11'h023]}, 32'hA5);

        // Valid held high across two byte loads; fields switch after the first accept.
        sb.push_back('{rdata: 32'h00000080, err: 1'b0, lat: 2});
        sb.push_back('{rdata: 32'hFFFFFFC3, err: 1'b0, lat: 5});
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b1;
        req_addr     = 11'h040;
        accepts   = 0;
        got       = 0;
        t         = 0;
        acc_edge2 = -1;
        for (int i = 0; i < 20 && got < 2; i++) begin
            acc = req_valid && req_ready;
            @(posedge clk);
            if (acc) begin
                accepts++;
                if (accepts == 2) acc_edge2 = t;
            end
            @(negedge clk);
            t++;
            if (acc && accepts == 1) begin
                req_unsigned = 1'b0;
                req_addr     = 11'h050;
            end
            if (acc && accepts == 2) req_valid = 1'b0;
            if (rsp_valid) begin
                got++;
                check("b2b_sb", {31'b0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b2b_rdata", rsp_rdata, e.rdata);
                    check("b2b_cycle", t, e.lat);
                end
            end
        end
        check("b2b_got", got, 2);
        check("b2b_second_edge", acc_edge2, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_no_dup", {31'b0, rsp_valid}, 32'd0);
        end
        check("b2b_accepts", accepts, 2);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
